// File: rtl/cond_unit_pkg.sv
// Shared condition-code definitions for the ARM execute stage.
package cond_unit_pkg;

  typedef enum logic [3:0] {
    C_EQ = 4'b0000,
    C_NE = 4'b0001,
    C_CS = 4'b0010,
    C_CC = 4'b0011,
    C_MI = 4'b0100,
    C_PL = 4'b0101,
    C_VS = 4'b0110,
    C_VC = 4'b0111,
    C_HI = 4'b1000,
    C_LS = 4'b1001,
    C_GE = 4'b1010,
    C_LT = 4'b1011,
    C_GT = 4'b1100,
    C_LE = 4'b1101,
    C_AL = 4'b1110,
    C_NV = 4'b1111
  } cond_t;

  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FV = 0;

endpackage

// File: rtl/cond_unit_check.sv
// Combinational ARM condition evaluation against an NZCV vector.
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FN];
  assign z = flags[FZ];
  assign c = flags[FC];
  assign v = flags[FV];

  always_comb begin
    pass = 1'b0;
    unique case (cond_t'(cond))
      C_EQ: pass = z;
      C_NE: pass = ~z;
      C_CS: pass = c;
      C_CC: pass = ~c;
      C_MI: pass = n;
      C_PL: pass = ~n;
      C_VS: pass = v;
      C_VC: pass = ~v;
      C_HI: pass = c & ~z;
      C_LS: pass = ~c | z;
      C_GE: pass = (n == v);
      C_LT: pass = (n != v);
      C_GT: pass = ~z & (n == v);
      C_LE: pass = z | (n != v);
      C_AL: pass = 1'b1;
      C_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: NZCV register, predication and E/M register.
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidE,
  input  logic [3:0]       CondE,
  input  logic [1:0]       FlagWE,
  input  logic [3:0]       ALUFlagsE,
  input  logic [WIDTH-1:0] ResultE,
  input  logic [RA_W-1:0]  WA3E,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             MemtoRegE,
  input  logic             BranchE,
  input  logic             StallE,
  input  logic             FlushM,
  output logic             CondExE,
  output logic             PCSrcE,
  output logic [3:0]       Flags,
  output logic             ValidM,
  output logic [WIDTH-1:0] ResultM,
  output logic [RA_W-1:0]  WA3M,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegM
);

  logic pass;
  logic fwe;

  cond_check u_check (
    .cond  (CondE),
    .flags (Flags),
    .pass  (pass)
  );

  assign CondExE = ValidE & pass;
  assign PCSrcE  = CondExE & BranchE & ~StallE;
  assign fwe     = CondExE & ~StallE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags <= 4'b0000;
    end else if (fwe) begin
      if (FlagWE[1]) Flags[3:2] <= ALUFlagsE[3:2];
      if (FlagWE[0]) Flags[1:0] <= ALUFlagsE[1:0];
    end
  end

  // Flush and stall both insert a bubble; data fields hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ValidM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      ResultM   <= '0;
      WA3M      <= '0;
    end else if (FlushM || StallE) begin
      ValidM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end else begin
      ValidM    <= ValidE;
      RegWriteM <= RegWriteE & CondExE;
      MemWriteM <= MemWriteE & CondExE;
      MemtoRegM <= MemtoRegE;
      ResultM   <= ResultE;
      WA3M      <= WA3E;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit.
module tb_cond_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidE;
  logic [3:0]  CondE;
  logic [1:0]  FlagWE;
  logic [3:0]  ALUFlagsE;
  logic [31:0] ResultE;
  logic [3:0]  WA3E;
  logic        RegWriteE, MemWriteE, MemtoRegE;
  logic        BranchE, StallE, FlushM;
  logic        CondExE, PCSrcE;
  logic [3:0]  Flags;
  logic        ValidM;
  logic [31:0] ResultM;
  logic [3:0]  WA3M;
  logic        RegWriteM, MemWriteM, MemtoRegM;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cond_unit #(.WIDTH(32), .RA_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ValidE    (ValidE),
    .CondE     (CondE),
    .FlagWE    (FlagWE),
    .ALUFlagsE (ALUFlagsE),
    .ResultE   (ResultE),
    .WA3E      (WA3E),
    .RegWriteE (RegWriteE),
    .MemWriteE (MemWriteE),
    .MemtoRegE (MemtoRegE),
    .BranchE   (BranchE),
    .StallE    (StallE),
    .FlushM    (FlushM),
    .CondExE   (CondExE),
    .PCSrcE    (PCSrcE),
    .Flags     (Flags),
    .ValidM    (ValidM),
    .ResultM   (ResultM),
    .WA3M      (WA3M),
    .RegWriteM (RegWriteM),
    .MemWriteM (MemWriteM),
    .MemtoRegM (MemtoRegM)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    ValidE = 0; CondE = 4'hE; FlagWE = 0; ALUFlagsE = 0;
    ResultE = 0; WA3E = 0;
    RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0;
    BranchE = 0; StallE = 0; FlushM = 0;
    #12;
    check("rst_flags", Flags, 4'h0);
    check("rst_validm", ValidM, 0);
    check("rst_regwm", RegWriteM, 0);
    check("rst_resm", ResultM, 0);
    @(negedge clk);
    reset = 1'b1;

    // AL register write
    ValidE = 1; CondE = 4'hE; RegWriteE = 1;
    ResultE = 32'h1234; WA3E = 4'd5;
    tick;
    check("al_regwm", RegWriteM, 1);
    check("al_resm", ResultM, 32'h1234);
    check("al_wa3m", WA3M, 5);
    check("al_validm", ValidM, 1);
    check("al_flags", Flags, 4'h0);

    // SUBS setting Z
    RegWriteE = 0; FlagWE = 2'b11; ALUFlagsE = 4'b0100;
    settle;
    check("subs_condex", CondExE, 1);
    tick;
    check("subs_flags", Flags, 4'b0100);

    // EQ branch taken
    FlagWE = 0; CondE = 4'h0; BranchE = 1;
    settle;
    check("eq_condex", CondExE, 1);
    check("eq_pcsrc", PCSrcE, 1);

    // NE fails: still valid in M, no write
    CondE = 4'h1; BranchE = 0; RegWriteE = 1;
    settle;
    check("ne_condex", CondExE, 0);
    tick;
    check("ne_regwm", RegWriteM, 0);
    check("ne_validm", ValidM, 1);
    RegWriteE = 0;

    // Partial flag updates
    CondE = 4'hE; FlagWE = 2'b11; ALUFlagsE = 4'b1111;
    tick;
    check("pf_all", Flags, 4'b1111);
    FlagWE = 2'b10; ALUFlagsE = 4'b0000;
    tick;
    check("pf_nz", Flags, 4'b0011);
    FlagWE = 2'b01;
    tick;
    check("pf_cv", Flags, 4'b0000);

    // Failed condition must not write flags
    CondE = 4'h0; FlagWE = 2'b11; ALUFlagsE = 4'b1111;
    tick;
    check("fail_nowr", Flags, 4'b0000);

    // Invalid instruction must not write flags
    ValidE = 0; CondE = 4'hE;
    settle;
    check("inv_condex", CondExE, 0);
    tick;
    check("inv_nowr", Flags, 4'b0000);
    ValidE = 1;

    // Stall holds flags and bubbles M
    StallE = 1; ALUFlagsE = 4'b1010; BranchE = 1;
    settle;
    check("stall_pcsrc", PCSrcE, 0);
    tick;
    check("stall_flags", Flags, 4'b0000);
    check("stall_validm", ValidM, 0);
    StallE = 0; BranchE = 0;
    tick;
    check("unstall_flags", Flags, 4'b1010);
    FlagWE = 0;

    // Signed conditions, N=1 V=0 Z=0 C=1
    CondE = 4'hB; settle; check("lt_pass", CondExE, 1);
    CondE = 4'hA; settle; check("ge_fail", CondExE, 0);
    CondE = 4'hC; settle; check("gt_fail", CondExE, 0);
    CondE = 4'hD; settle; check("le_pass", CondExE, 1);
    CondE = 4'h8; settle; check("hi_pass", CondExE, 1);
    CondE = 4'h9; settle; check("ls_fail", CondExE, 0);

    CondE = 4'hE; FlagWE = 2'b11; ALUFlagsE = 4'b1001;
    tick;
    check("nv_flags", Flags, 4'b1001);
    FlagWE = 0;
    CondE = 4'hC; settle; check("gt_pass", CondExE, 1);
    CondE = 4'hF; settle; check("never", CondExE, 0);

    // Flush and stall together with a store
    CondE = 4'hE; MemWriteE = 1; FlushM = 1; StallE = 1;
    tick;
    check("fs_memwm", MemWriteM, 0);
    check("fs_validm", ValidM, 0);
    FlushM = 0; StallE = 0; RegWriteE = 1; ResultE = 32'hBEEF;
    tick;
    check("st_memwm", MemWriteM, 1);
    check("st_validm", ValidM, 1);

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    check("ar_flags", Flags, 4'h0);
    check("ar_validm", ValidM, 0);
    check("ar_regwm", RegWriteM, 0);
    check("ar_memwm", MemWriteM, 0);
    check("ar_resm", ResultM, 0);
    check("ar_wa3m", WA3M, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
